// File: rtl/seq_signed_multiplier.sv
`default_nettype none
// ============================================================================
// Module   : seq_signed_multiplier
// Brief    : Signed-magnitude add-and-shift multiplier with a one-hot FSM.
// Revision : 1.0 - initial release
// ============================================================================
module seq_signed_multiplier #(
    parameter int N = 8
) (
    input  logic           clk,
    input  logic           resest,
    input  logic           start,
    input  logic           bs,
    input  logic [N-1:0]   b_mag,
    input  logic           qs,
    input  logic [N-1:0]   q_mag,
    output logic           busy,
    output logic           done,
    output logic           ps,
    output logic [2*N-1:0] p_mag,
    output logic [4:0]     y
);

    localparam int PW = $clog2(N + 1);

    typedef enum logic [4:0] {
        S_IDLE  = 5'b00001,
        S_LOAD  = 5'b00010,
        S_ADD   = 5'b00100,
        S_SHIFT = 5'b01000,
        S_DONE  = 5'b10000
    } state_t;

    state_t          r_state;
    state_t          w_next;
    logic [N-1:0]    r_b;
    logic [N-1:0]    r_a;
    logic [N-1:0]    r_q;
    logic            r_e;
    logic            r_bs;
    logic            r_qs;
    logic            r_as;
    logic [PW-1:0]   r_p;
    logic            r_ps;
    logic [2*N-1:0]  r_pmag;

    logic            w_zero;
    logic            w_last;
    logic [N:0]      w_sum;
    logic [N-1:0]    w_a_sh;
    logic [N-1:0]    w_q_sh;

    assign w_zero = (r_b == '0) || (r_q == '0);
    assign w_last = (r_p == PW'(1));
    assign w_sum  = {1'b0, r_a} + {1'b0, r_b};
    assign w_a_sh = {r_e, r_a[N-1:1]};
    assign w_q_sh = {r_a[0], r_q[N-1:1]};

    always_ff @(posedge clk or posedge resest) begin
        if (resest) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Unreachable encodings fall through to default and recover via IDLE.
    always_comb begin
        w_next = S_IDLE;
        case (r_state)
            S_IDLE:  w_next = start ? S_LOAD : S_IDLE;
            S_LOAD:  w_next = w_zero ? S_DONE : S_ADD;
            S_ADD:   w_next = S_SHIFT;
            S_SHIFT: w_next = w_last ? S_DONE : S_ADD;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge resest) begin
        if (resest) begin
            r_b    <= '0;
            r_a    <= '0;
            r_q    <= '0;
            r_e    <= 1'b0;
            r_bs   <= 1'b0;
            r_qs   <= 1'b0;
            r_as   <= 1'b0;
            r_p    <= '0;
            r_ps   <= 1'b0;
            r_pmag <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_b  <= b_mag;
                        r_q  <= q_mag;
                        r_bs <= bs;
                        r_qs <= qs;
                    end
                end
                S_LOAD: begin
                    r_a  <= '0;
                    r_e  <= 1'b0;
                    r_p  <= PW'(N);
                    r_as <= r_bs ^ r_qs;
                    // Zero product is always reported positive.
                    if (w_zero) begin
                        r_ps   <= 1'b0;
                        r_pmag <= '0;
                    end
                end
                S_ADD: begin
                    if (r_q[0]) begin
                        {r_e, r_a} <= w_sum;
                    end
                end
                S_SHIFT: begin
                    r_a <= w_a_sh;
                    r_q <= w_q_sh;
                    r_e <= 1'b0;
                    r_p <= r_p - PW'(1);
                    if (w_last) begin
                        r_ps   <= r_as;
                        r_pmag <= {w_a_sh, w_q_sh};
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign y     = r_state;
    assign busy  = ~r_state[0];
    assign done  = (r_state == S_DONE);
    assign ps    = r_ps;
    assign p_mag = r_pmag;

endmodule
`default_nettype wire

// File: tb/tb_seq_signed_multiplier.sv
`default_nettype none
// ============================================================================
// Module   : tb_seq_signed_multiplier
// Brief    : Scoreboard bench for seq_signed_multiplier with random operands.
// Revision : 1.0 - initial release
// ============================================================================
module tb_seq_signed_multiplier;

    localparam int N = 8;

    logic           clk;
    logic           resest;
    logic           start;
    logic           bs;
    logic [N-1:0]   b_mag;
    logic           qs;
    logic [N-1:0]   q_mag;
    logic           busy;
    logic           done;
    logic           ps;
    logic [2*N-1:0] p_mag;
    logic [4:0]     y;

    typedef struct packed {
        logic           s;
        logic [2*N-1:0] m;
    } exp_t;

    exp_t sb_q[$];
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;

    seq_signed_multiplier #(.N(N)) dut (
        .clk   (clk),
        .resest(resest),
        .start (start),
        .bs    (bs),
        .b_mag (b_mag),
        .qs    (qs),
        .q_mag (q_mag),
        .busy  (busy),
        .done  (done),
        .ps    (ps),
        .p_mag (p_mag),
        .y     (y)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got=%0h expected=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: magnitudes multiply, signs XOR, zero is always positive.
    function automatic exp_t model(input logic sb, input logic [N-1:0] b,
                                   input logic sq, input logic [N-1:0] q);
        exp_t e;
        int unsigned prod;
        prod = int'(b) * int'(q);
        e.m  = prod[2*N-1:0];
        e.s  = (prod != 0) ? (sb ^ sq) : 1'b0;
        return e;
    endfunction

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (!resest && done) begin
            if (sb_q.size() == 0) begin
                chk("unexpected_done", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                chk("ps", {31'd0, ps}, {31'd0, e.s});
                chk("p_mag", {16'd0, p_mag}, {16'd0, e.m});
            end
        end
    end

    task automatic wait_idle();
        int k;
        k = 0;
        @(negedge clk);
        while (busy && k < 50) begin
            @(negedge clk);
            k++;
        end
        if (busy) chk("idle_timeout", 32'd1, 32'd0);
    endtask

    task automatic run_op(input logic sb, input logic [N-1:0] b,
                          input logic sq, input logic [N-1:0] q, input bit disturb);
        int  lat;
        int  exp_lat;
        bit  got;
        wait_idle();
        bs = sb; b_mag = b; qs = sq; q_mag = q;
        start = 1'b1;
        sb_q.push_back(model(sb, b, sq, q));
        exp_lat = (b == 0 || q == 0) ? 2 : 2 * N + 2;
        @(posedge clk); #1;
        start = 1'b0;
        bs = $urandom; b_mag = $urandom; qs = $urandom; q_mag = $urandom;
        lat = 1;
        got = 0;
        for (int k = 0; k < 60 && !got; k++) begin
            if (disturb && k == 4) begin
                start = 1'b1;
                b_mag = $urandom_range(1, 255);
                q_mag = $urandom_range(1, 255);
            end
            if (disturb && k == 7) start = 1'b0;
            @(posedge clk); #1;
            lat++;
            if (done) got = 1;
        end
        start = 1'b0;
        chk("done_seen", {31'd0, got}, 32'd1);
        chk("latency", lat, exp_lat);
    endtask

    initial begin
        int done_cyc[3];
        int nd;
        int k;
        resest = 1'b0; start = 1'b0; bs = 1'b0; b_mag = '0; qs = 1'b0; q_mag = '0;

        // Asynchronous reset before any clock edge.
        #2 resest = 1'b1;
        #1;
        chk("rst_y", {27'd0, y}, 32'h1);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_ps", {31'd0, ps}, 32'd0);
        chk("rst_pmag", {16'd0, p_mag}, 32'd0);
        @(negedge clk); @(negedge clk);
        resest = 1'b0;

        // Directed cases.
        run_op(1'b0, 8'd13, 1'b1, 8'd11, 1'b0);
        run_op(1'b1, 8'd255, 1'b1, 8'd255, 1'b0);
        run_op(1'b1, 8'd0, 1'b0, 8'd200, 1'b0);
        run_op(1'b1, 8'd77, 1'b1, 8'd0, 1'b0);
        run_op(1'b0, 8'd255, 1'b1, 8'd1, 1'b0);
        run_op(1'b0, 8'd7, 1'b0, 8'd9, 1'b1);

        // Reset during SHIFT discards the operation.
        wait_idle();
        bs = 1'b0; b_mag = 8'd7; qs = 1'b0; q_mag = 8'd9; start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        k = 0;
        @(negedge clk);
        while (y != 5'b01000 && k < 40) begin
            @(negedge clk);
            k++;
        end
        chk("reach_shift", {27'd0, y}, 32'h8);
        #2 resest = 1'b1;
        #1;
        chk("mid_rst_y", {27'd0, y}, 32'h1);
        chk("mid_rst_busy", {31'd0, busy}, 32'd0);
        chk("mid_rst_done", {31'd0, done}, 32'd0);
        chk("mid_rst_pmag", {16'd0, p_mag}, 32'd0);
        @(negedge clk); resest = 1'b0;
        repeat (25) @(negedge clk);
        chk("mid_rst_y_after", {27'd0, y}, 32'h1);

        // Randomized operations with occasional zero operands.
        for (int i = 0; i < 20; i++) begin
            logic [N-1:0] rb, rq;
            rb = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom_range(0, 255));
            rq = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom_range(0, 255));
            run_op(1'($urandom), rb, 1'($urandom), rq, bit'($urandom_range(0, 3) == 0));
        end

        // start held high: back-to-back operations.
        wait_idle();
        bs = 1'b0; b_mag = 8'd3; qs = 1'b0; q_mag = 8'd5; start = 1'b1;
        for (int i = 0; i < 3; i++) sb_q.push_back(model(1'b0, 8'd3, 1'b0, 8'd5));
        nd = 0;
        k = 0;
        while (nd < 3 && k < 100) begin
            @(negedge clk);
            k++;
            if (done) begin
                done_cyc[nd] = cyc;
                nd++;
            end
        end
        start = 1'b0;
        chk("b2b_count", nd, 3);
        if (nd == 3) begin
            chk("b2b_gap1", done_cyc[1] - done_cyc[0], 19);
            chk("b2b_gap2", done_cyc[2] - done_cyc[1], 19);
        end

        repeat (5) @(negedge clk);
        chk("scoreboard_empty", sb_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
